// File: rtl/main_memory_requester.sv
// ---------------------------------------------------------------------------
// main_memory_requester
//
// Purpose:
//   Services cache line-fill misses against main memory. For a miss with a
//   dirty victim it first writes the victim line back, idles for one GAP
//   cycle, then reads the requested line. The returned line is registered
//   into fill_data and announced with a one-cycle fill_valid pulse.
//
//   States: IDLE -> (WB_REQ -> GAP ->) RD_REQ -> DONE -> IDLE
//
// Handshakes:
//   miss_valid/miss_ready : a miss is accepted on a rising edge where both
//                           are 1. miss_ready is 1 only in IDLE, so
//                           miss_valid is ignored during a transaction.
//   request/ready (memory): a request level stays high until
//                           main_memory_ready is sampled with it, and falls
//                           on the following cycle. A ready seen while no
//                           request is pending is a stray completion and is
//                           ignored.
//
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   miss_valid / miss_ready      miss handshake
//   miss_addr, miss_dirty        fill address; victim needs writeback
//   victim_addr, victim_data     writeback address / data
//   fill_valid, fill_data        one-cycle fill pulse / returned line
//   main_memory_read_request     read request level to memory
//   main_memory_write_request    write request level to memory
//   main_memory_address          registered memory address
//   main_memory_write_data       registered memory write data
//   main_memory_read_data        memory read data
//   main_memory_ready            memory completion pulse
//   error                        sticky timeout flag
//   dbg_state_o                  current FSM state (debug visibility)
//
// Optional feature:
//   MAIN_MEMORY_REQUESTER_TIMEOUT_EN -- when defined, a request that sees no
//   ready within TIMEOUT_CYCLES cycles is abandoned: error is set (sticky
//   until reset), fill_data is loaded with 0 and fill_valid still pulses.
//   When undefined the block waits for ready indefinitely and error is 0.
// ---------------------------------------------------------------------------

`ifndef MAIN_MEMORY_ADDRESS_WIDTH
`define MAIN_MEMORY_ADDRESS_WIDTH 32
`endif
`ifndef MAIN_MEMORY_DATA_WIDTH
`define MAIN_MEMORY_DATA_WIDTH 32
`endif

module main_memory_requester #(
  parameter int ADDR_WIDTH     = `MAIN_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = `MAIN_MEMORY_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  miss_dirty,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic [DATA_WIDTH-1:0] victim_data,
  output logic                  fill_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  main_memory_read_request,
  output logic                  main_memory_write_request,
  output logic [ADDR_WIDTH-1:0] main_memory_address,
  output logic [DATA_WIDTH-1:0] main_memory_write_data,
  input  logic [DATA_WIDTH-1:0] main_memory_read_data,
  input  logic                  main_memory_ready,
  output logic                  error,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB_REQ = 3'd1,
    GAP    = 3'd2,
    RD_REQ = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Reject a configuration whose timeout could never be met.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] miss_addr_q;   // fill address kept for after GAP
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] fill_data_q;

`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            error_q;
  logic            tmo_hit;

  // The counter starts at 0 on the first request cycle, so reaching
  // TIMEOUT_CYCLES-1 without ready means the request has been high for
  // TIMEOUT_CYCLES cycles.
  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_data_q <= '0;
`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid) begin
            miss_addr_q <= miss_addr;
`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
            if (miss_dirty) begin
              // Address/data registers change only on request entry.
              mem_addr_q  <= victim_addr;
              mem_wdata_q <= victim_data;
              state_q     <= WB_REQ;
            end else begin
              mem_addr_q  <= miss_addr;
              state_q     <= RD_REQ;
            end
          end
        end

        WB_REQ: begin
          if (main_memory_ready) begin
            state_q <= GAP;
          end
`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
          else if (tmo_hit) begin
            error_q     <= 1'b1;
            fill_data_q <= '0;
            state_q     <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
`endif
        end

        GAP: begin
          // Exactly one quiet cycle between writeback and read; any ready
          // seen here is stray and deliberately not looked at.
          mem_addr_q <= miss_addr_q;
          state_q    <= RD_REQ;
`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
          tmo_cnt_q  <= '0;
`endif
        end

        RD_REQ: begin
          if (main_memory_ready) begin
            fill_data_q <= main_memory_read_data;
            state_q     <= DONE;
          end
`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
          else if (tmo_hit) begin
            error_q     <= 1'b1;
            fill_data_q <= '0;
            state_q     <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
`endif
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All handshake/request outputs decode from the registered state only,
  // so an asynchronous reset clears them immediately.
  assign miss_ready                = (state_q == IDLE);
  assign main_memory_write_request = (state_q == WB_REQ);
  assign main_memory_read_request  = (state_q == RD_REQ);
  assign fill_valid                = (state_q == DONE);
  assign fill_data                 = fill_data_q;
  assign main_memory_address       = mem_addr_q;
  assign main_memory_write_data    = mem_wdata_q;
  assign dbg_state_o               = state_q;

`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

`ifndef SYNTHESIS
  a_req_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(main_memory_read_request && main_memory_write_request));
`endif

endmodule

// File: tb/tb_main_memory_requester.sv
// ---------------------------------------------------------------------------
// tb_main_memory_requester
//
// Table of miss records applied in a loop, plus hand-written sequences for
// held miss_valid with stray completions, reset in the middle of a read and
// (when MAIN_MEMORY_REQUESTER_TIMEOUT_EN is defined) the timeout path.
// A behavioural memory responds to requests after a programmable delay.
// Expected fill data and fill latency are queued when a miss is accepted and
// compared when fill_valid pulses.
// ---------------------------------------------------------------------------
module tb_main_memory_requester;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic          miss_valid = 1'b0;
  logic          miss_ready;
  logic [AW-1:0] miss_addr = '0;
  logic          miss_dirty = 1'b0;
  logic [AW-1:0] victim_addr = '0;
  logic [DW-1:0] victim_data = '0;
  logic          fill_valid;
  logic [DW-1:0] fill_data;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          error;
  logic [2:0]    dbg_state;

  main_memory_requester #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .miss_valid               (miss_valid),
    .miss_ready               (miss_ready),
    .miss_addr                (miss_addr),
    .miss_dirty               (miss_dirty),
    .victim_addr              (victim_addr),
    .victim_data              (victim_data),
    .fill_valid               (fill_valid),
    .fill_data                (fill_data),
    .main_memory_read_request (rd_req),
    .main_memory_write_request(wr_req),
    .main_memory_address      (mem_addr),
    .main_memory_write_data   (mem_wdata),
    .main_memory_read_data    (mem_rdata),
    .main_memory_ready        (mem_ready),
    .error                    (error),
    .dbg_state_o              (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- memory model / responder ----------------
  logic [DW-1:0] mem [256];
  int  resp_lat   = 0;
  bit  silent     = 1'b0;
  bit  stray_mode = 1'b0;

  initial begin : responder
    int cnt;
    bit real_q;
    bit real_now;
    cnt       = 0;
    real_q    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      real_now = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if ((rd_req || wr_req) && !silent && !real_q) begin
        if (cnt >= resp_lat) begin
          real_now = 1'b1;
          cnt      = 0;
          if (wr_req) mem[mem_addr[7:0]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[7:0]];
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      real_q = real_now;
      if (real_now) begin
        mem_ready = 1'b1;
      end else if (stray_mode && !rd_req && !wr_req && !reset) begin
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];

  logic [AW-1:0] exp_wr_addr = '0;
  logic [DW-1:0] exp_wr_data = '0;
  logic [AW-1:0] exp_rd_addr = '0;
  logic [DW-1:0] cur_fill    = '0;
  int            cur_lat     = 0;
  int            fill_cnt    = 0;
  int            acc_cnt     = 0;
  int            wr_rise_cnt = 0;
  int            rd_rise_cnt = 0;

  initial begin : monitor
    bit p_rd, p_wr, p_rdy, p_fill, gap_pend;
    logic [DW-1:0] e;
    int l, a;
    p_rd = 0; p_wr = 0; p_rdy = 0; p_fill = 0; gap_pend = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_rd = 0; p_wr = 0; p_rdy = 0; p_fill = 0; gap_pend = 0;
      end else begin
        check("req_exclusive", 32'(rd_req && wr_req), 0);
        if (wr_req) begin
          check("wr_addr", mem_addr, exp_wr_addr);
          check("wr_data", mem_wdata, exp_wr_data);
          if (!p_wr) wr_rise_cnt++;
        end
        if (rd_req) begin
          check("rd_addr", mem_addr, exp_rd_addr);
          if (!p_rd) rd_rise_cnt++;
        end
        if (!silent && p_rd && !p_rdy) check("rd_hold", rd_req, 1);
        if (!silent && p_wr && !p_rdy) check("wr_hold", wr_req, 1);
        if (p_rd && p_rdy) check("rd_fall", rd_req, 0);
        if (gap_pend) begin
          check("gap_then_rd", rd_req, 1);
          gap_pend = 0;
        end
        if (p_wr && p_rdy) begin
          check("gap_wr_low", wr_req, 0);
          check("gap_rd_low", rd_req, 0);
          check("gap_addr_hold", mem_addr, exp_wr_addr);
          gap_pend = 1;
        end
        if (miss_valid && miss_ready) begin
          exp_q.push_back(cur_fill);
          lat_q.push_back(cur_lat);
          acc_q.push_back(cyc);
          acc_cnt++;
        end
        if (fill_valid) begin
          fill_cnt++;
          check("fill_single_cycle", p_fill, 0);
          check("done_addr_hold", mem_addr, exp_rd_addr);
          check("fill_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            a = acc_q.pop_front();
            check("fill_data", fill_data, e);
            check("fill_latency", cyc - a, l);
          end
        end
        p_rd = rd_req; p_wr = wr_req; p_rdy = mem_ready; p_fill = fill_valid;
      end
    end
  end

  // ---------------- vectors and driver tasks ----------------
  typedef struct {
    logic          dirty;
    logic [AW-1:0] miss_addr;
    logic [AW-1:0] victim_addr;
    logic [DW-1:0] victim_data;
    int            lat;
    logic [DW-1:0] exp_fill;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic d, input logic [AW-1:0] ma, input logic [AW-1:0] va,
                              input logic [DW-1:0] vd, input int lat, input logic [DW-1:0] ef);
    vec_t v;
    v.dirty = d; v.miss_addr = ma; v.victim_addr = va; v.victim_data = vd;
    v.lat = lat; v.exp_fill = ef;
    return v;
  endfunction

  // Accept cycle to fill cycle: clean = accept, lat+1 read cycles, DONE;
  // dirty adds lat+1 write cycles and one GAP cycle.
  function automatic int calc_lat(input vec_t v);
    return v.dirty ? (4 + 2 * v.lat) : (2 + v.lat);
  endfunction

  task automatic do_miss(input vec_t v, input int exp_lat, input bit wait_fill);
    int n, start, w0, r0;
    n = 0;
    while (!miss_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_before_miss", miss_ready, 1);
    exp_wr_addr = v.victim_addr;
    exp_wr_data = v.victim_data;
    exp_rd_addr = v.miss_addr;
    cur_fill    = v.exp_fill;
    cur_lat     = exp_lat;
    resp_lat    = v.lat;
    miss_addr   = v.miss_addr;
    miss_dirty  = v.dirty;
    victim_addr = v.victim_addr;
    victim_data = v.victim_data;
    miss_valid  = 1'b1;
    start = fill_cnt; w0 = wr_rise_cnt; r0 = rd_rise_cnt;
    @(posedge clk); #1;
    miss_valid  = 1'b0;
    // Scramble the inputs so any late sampling shows up as a wrong address.
    miss_addr   = AW'($urandom_range(0, 65535));
    miss_dirty  = 1'($urandom_range(0, 1));
    victim_addr = AW'($urandom_range(0, 65535));
    victim_data = DW'($urandom_range(0, 65535));
    if (wait_fill) begin
      n = 0;
      while (fill_cnt == start && n < 200) begin @(posedge clk); #1; n++; end
      check("fill_arrived", 32'(fill_cnt != start), 1);
      check("wr_req_count", wr_rise_cnt - w0, v.dirty ? 1 : 0);
      check("rd_req_count", rd_rise_cnt - r0, 1);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rd_req"},     rd_req, 0);
    check({tag, "_wr_req"},     wr_req, 0);
    check({tag, "_fill_valid"}, fill_valid, 0);
    check({tag, "_fill_data"},  fill_data, 0);
    check({tag, "_addr"},       mem_addr, 0);
    check({tag, "_wdata"},      mem_wdata, 0);
    check({tag, "_error"},      error, 0);
    check({tag, "_miss_ready"}, miss_ready, 1);
    check({tag, "_state"},      dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int n, start, a0;
    vec_t sv;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 16'hA5A5;
    mem[8'h44] = 16'h7777;
    mem[8'hFF] = 16'hC3C3;

    //             dirty miss      victim    vdata     lat exp_fill
    vecs[0] = mk(1'b0, 16'h0040, 16'h1111, 16'h2222, 2, 16'hA5A5);
    vecs[1] = mk(1'b1, 16'h0040, 16'h0080, 16'h1234, 2, 16'hA5A5);
    vecs[2] = mk(1'b0, 16'h0080, 16'h3333, 16'h4444, 0, 16'h1234);
    vecs[3] = mk(1'b1, 16'h0010, 16'h0010, 16'hBEEF, 1, 16'hBEEF);
    vecs[4] = mk(1'b0, 16'hFFFF, 16'h5555, 16'h6666, 3, 16'hC3C3);
    vecs[5] = mk(1'b1, 16'h0044, 16'h0000, 16'hFFFF, 0, 16'h7777);
    vecs[6] = mk(1'b0, 16'h0000, 16'h7777, 16'h8888, 1, 16'hFFFF);

    // Reset state, checked while reset is still held.
    #12;
    check_reset_outs("reset");
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven misses.
    for (int i = 0; i < 7; i++) begin
      do_miss(vecs[i], calc_lat(vecs[i]), 1'b1);
    end

    // miss_valid held across several transactions with stray readies
    // injected whenever no request is pending (IDLE, GAP, DONE).
    sv = mk(1'b1, 16'h0044, 16'h0090, 16'h5555, 1, 16'h7777);
    exp_wr_addr = sv.victim_addr; exp_wr_data = sv.victim_data;
    exp_rd_addr = sv.miss_addr;   cur_fill = sv.exp_fill;
    cur_lat = calc_lat(sv);       resp_lat = sv.lat;
    stray_mode = 1'b1;
    miss_addr = sv.miss_addr; miss_dirty = sv.dirty;
    victim_addr = sv.victim_addr; victim_data = sv.victim_data;
    start = fill_cnt; a0 = acc_cnt;
    miss_valid = 1'b1;
    n = 0;
    while ((fill_cnt - start) < 3 && n < 300) begin @(posedge clk); #1; n++; end
    miss_valid = 1'b0;
    // Stray readies in IDLE with no miss must not start anything.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("idle_stray_no_req", 32'(rd_req || wr_req), 0);
      check("idle_stray_state", dbg_state, 0);
    end
    stray_mode = 1'b0;
    check("held_fills", fill_cnt - start, 3);
    check("held_accepts", acc_cnt - a0, 3);

    // Reset in the middle of RD_REQ: requests drop at once, no fill.
    silent = 1'b1;
    do_miss(vecs[0], calc_lat(vecs[0]), 1'b0);
    @(posedge clk); #1;
    check("abort_in_rd", rd_req, 1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outs("abort");
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    silent = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    start = fill_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("no_fill_after_abort", fill_cnt - start, 0);
    do_miss(vecs[0], calc_lat(vecs[0]), 1'b1);

`ifdef MAIN_MEMORY_REQUESTER_TIMEOUT_EN
    // Silent memory: request stays up TMO cycles, then DONE with data 0.
    silent = 1'b1;
    sv = vecs[0];
    sv.exp_fill = '0;
    do_miss(sv, TMO + 1, 1'b1);
    silent = 1'b0;
    check("timeout_error_set", error, 1);
    do_miss(vecs[1], calc_lat(vecs[1]), 1'b1);
    check("timeout_error_sticky", error, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("timeout_error_cleared", error, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
`else
    check("error_tied_low", error, 0);
`endif

    // Writeback of the REQ-style dirty miss landed in memory.
    check("mem_0x80_written", mem[8'h80], 16'h1234);
    check("mem_0x10_written", mem[8'h10], 16'hBEEF);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/main_memory_requester.md
MAIN_MEMORY_REQUESTER -- requirements
Module: main_memory_requester

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default MAIN_MEMORY_ADDRESS_WIDTH, the memory byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default MAIN_MEMORY_DATA_WIDTH, the block data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the timeout limit in cycles.
REQ-004 The block SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port miss_valid  in  1  cache requests a line fill.
REQ-007 The block SHALL have port miss_ready  out  1  block can accept a miss.
REQ-008 The block SHALL have port miss_addr  in  ADDR_WIDTH  fill address.
REQ-009 The block SHALL have port miss_dirty  in  1  victim line needs writeback before the fill.
REQ-010 The block SHALL have port victim_addr  in  ADDR_WIDTH  writeback address.
REQ-011 The block SHALL have port victim_data  in  DATA_WIDTH  writeback data.
REQ-012 The block SHALL have port fill_valid  out  1  one-cycle pulse: fill_data is valid.
REQ-013 The block SHALL have port fill_data  out  DATA_WIDTH  returned line.
REQ-014 The block SHALL have port main_memory_read_request  out  1  read request to memory.
REQ-015 The block SHALL have port main_memory_write_request  out  1  write request to memory.
REQ-016 The block SHALL have port main_memory_address  out  ADDR_WIDTH  memory address.
REQ-017 The block SHALL have port main_memory_write_data  out  DATA_WIDTH  memory write data.
REQ-018 The block SHALL have port main_memory_read_data  in  DATA_WIDTH  memory read data.
REQ-019 The block SHALL have port main_memory_ready  in  1  memory completion pulse.
REQ-020 The block SHALL have port error  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have the states IDLE, WB_REQ, GAP, RD_REQ and DONE.
REQ-022 The FSM SHALL use a registered state; request outputs SHALL be decoded from state only.
REQ-023 In IDLE, miss_ready SHALL be 1; in every other state miss_ready SHALL be 0, and miss_valid SHALL be ignored.
REQ-024 When miss_valid=1 in IDLE, the block SHALL latch miss_addr, victim_addr and victim_data, then go to WB_REQ if miss_dirty=1, otherwise to RD_REQ.
REQ-025 In WB_REQ, main_memory_write_request SHALL be 1, main_memory_address SHALL be victim_addr, and main_memory_write_data SHALL be victim_data; on main_memory_ready=1 the FSM SHALL go to GAP.
REQ-026 In GAP, both request outputs SHALL be 0 for exactly one cycle, after which the FSM SHALL go to RD_REQ.
REQ-027 In RD_REQ, main_memory_read_request SHALL be 1 and main_memory_address SHALL be miss_addr; on main_memory_ready=1 the block SHALL register main_memory_read_data into fill_data and go to DONE.
REQ-028 In DONE, fill_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-029 fill_data SHALL hold its value until the next capture.
REQ-030 Read and write requests SHALL never be asserted in the same cycle.
REQ-031 Each request SHALL stay high continuously until main_memory_ready is sampled, and SHALL fall on the following cycle.
REQ-032 main_memory_address and main_memory_write_data SHALL be registered, and SHALL change only on entry to WB_REQ or RD_REQ (held through GAP, DONE and IDLE).
REQ-033 A main_memory_ready seen in IDLE, GAP or DONE is a stray completion and SHALL be ignored.
REQ-034 fill_valid SHALL occur exactly 1 cycle after ready is sampled in RD_REQ.
REQ-035 A miss SHALL be accepted again no earlier than the cycle after DONE.

Reset
REQ-036 While reset=1, state SHALL be IDLE, all requests 0, fill_valid 0, fill_data 0, address/write data 0, error 0, timeout counter 0, with outputs changing immediately (not at the next edge).
REQ-037 A reset during WB_REQ or RD_REQ SHALL abort the transaction with no fill_valid; the first miss after reset SHALL be accepted normally.

Configuration
REQ-038 With macro MAIN_MEMORY_REQUESTER_TIMEOUT_EN defined, a counter SHALL increment each cycle in WB_REQ or RD_REQ and clear on state entry.
REQ-039 With the macro defined, if the counter reaches TIMEOUT_CYCLES without ready, the block SHALL drop the request, set error=1 (sticky until reset), load fill_data=0, and go to DONE (fill_valid pulses).
REQ-040 Without the macro, the block SHALL wait for ready indefinitely, error SHALL be tied 0, and no counter SHALL exist.

Verification
REQ-041 Clean miss (miss_addr=0x40, memory word=0xA5A5, responder ready 2 cycles after request rises) -> one read request, fill_valid 4 cycles after acceptance, fill_data=0xA5A5, no write request.
REQ-042 Dirty miss (victim 0x80/0x1234, fill 0x40) -> write to 0x80 with data 0x1234, one GAP cycle with both requests low, read of 0x40, then fill_valid; memory[0x80]=0x1234 afterwards.
REQ-043 miss_valid held high through a transaction, plus a stray ready injected in GAP and DONE -> exactly one fill per accepted miss, and the FSM does not advance on a stray ready.
REQ-044 Reset asserted mid-RD_REQ -> requests low the same cycle, no fill_valid, and the next miss completes correctly.
REQ-045 With MAIN_MEMORY_REQUESTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, responder silent -> after 8 cycles the request drops, error=1, and fill_valid pulses with fill_data=0; error stays 1 until reset.
